// File: rtl/router_ingress_queue.sv
// Ingress FIFO in front of the four-port router: valid/ready enqueue, registered din/din_en/addr issue.
// Optional feature: ROUTER_INGRESS_DROPCNT_EN adds a saturating 16-bit drop counter on port drop_count.
module router_ingress_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [1:0]                   in_addr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         out_hold,
  output logic [DATA_WIDTH-1:0]        din,
  output logic                         din_en,
  output logic [1:0]                   addr,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef ROUTER_INGRESS_DROPCNT_EN
  ,
  output logic [15:0]                  drop_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = DATA_WIDTH + 2;

  logic [ENT_W-1:0]      r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_din;
  logic [1:0]            r_addr;
  logic                  r_din_en;
  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic [ENT_W-1:0]      w_head;

  assign w_ready = (r_count < CNT_W'(DEPTH));
  assign w_push  = in_valid && w_ready && !reset;
  assign w_pop   = !out_hold && (r_count != CNT_W'(0)) && !reset;
  assign w_head  = r_mem[r_rd_ptr];

  // Storage is intentionally not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_addr, in_data};
    end
  end

  // Pointers, occupancy and the registered issue port toward the router.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
      r_din    <= DATA_WIDTH'(0);
      r_addr   <= 2'd0;
      r_din_en <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_din    <= w_head[DATA_WIDTH-1:0];
        r_addr   <= w_head[ENT_W-1:DATA_WIDTH];
        r_din_en <= 1'b1;
      end else begin
        r_din_en <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ROUTER_INGRESS_DROPCNT_EN
  logic [15:0] r_drop_count;

  // Counts refused offers, saturating; cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_count <= 16'd0;
    end else if (in_valid && !w_ready && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end else begin
      r_drop_count <= r_drop_count;
    end
  end

  assign drop_count = r_drop_count;
`endif

  assign in_ready = w_ready;
  assign din      = r_din;
  assign din_en   = r_din_en;
  assign addr     = r_addr;
  assign count    = r_count;

endmodule

// File: tb/tb_router_ingress_queue.sv
// Directed self-checking bench for router_ingress_queue (DATA_WIDTH=32, DEPTH=4).
module tb_router_ingress_queue;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_addr;
  logic        in_valid;
  logic        in_ready;
  logic        out_hold;
  logic [31:0] din;
  logic        din_en;
  logic [1:0]  addr;
  logic [2:0]  count;
`ifdef ROUTER_INGRESS_DROPCNT_EN
  logic [15:0] drop_count;
`endif

  int errors = 0;
  int checks = 0;

  router_ingress_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_addr(in_addr),
    .in_valid(in_valid), .in_ready(in_ready), .out_hold(out_hold),
    .din(din), .din_en(din_en), .addr(addr), .count(count)
`ifdef ROUTER_INGRESS_DROPCNT_EN
    , .drop_count(drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_addr = 2'd3; out_hold = 1'b0;
    tick(); tick(); tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count_hi: got %0d expected 0", count); end
    checks++; if (din_en !== 1'b0) begin errors++; $display("FAIL reset_din_en_hi: got %b expected 0", din_en); end
    in_valid = 1'b0; reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (din_en !== 1'b0) begin errors++; $display("FAIL reset_din_en: got %b expected 0", din_en); end
    checks++; if (din !== 32'd0 || addr !== 2'd0) begin errors++; $display("FAIL reset_din_addr: got %h/%0d expected 0/0", din, addr); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_addr = 2'd2; in_data = 32'hA5A5_0001; out_hold = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd1 || din_en !== 1'b0) begin errors++; $display("FAIL single_accept: got count=%0d din_en=%b expected 1/0", count, din_en); end
    tick();
    checks++; if (din_en !== 1'b1 || addr !== 2'd2 || din !== 32'hA5A5_0001) begin
      errors++; $display("FAIL single_issue: got en=%b addr=%0d din=%h expected 1/2/a5a50001", din_en, addr, din); end
    tick();
    checks++; if (din_en !== 1'b0 || din !== 32'hA5A5_0001 || count !== 3'd0) begin
      errors++; $display("FAIL single_idle: got en=%b din=%h count=%0d expected 0/a5a50001/0", din_en, din, count); end
  endtask

  task automatic test_fill_hold();
    out_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = 2'(i); in_data = 32'(i + 1);
      tick();
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count%0d: got %0d expected %0d", i, count, i + 1); end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", in_ready); end
    in_data = 32'd5; in_addr = 2'd0;
    tick();
    checks++; if (count !== 3'd4 || din_en !== 1'b0) begin errors++; $display("FAIL fill_fifth: got count=%0d en=%b expected 4/0", count, din_en); end
    in_valid = 1'b0; out_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (din_en !== 1'b1 || din !== 32'(i + 1) || addr !== 2'(i) || count !== 3'(3 - i)) begin
        errors++; $display("FAIL drain%0d: got en=%b din=%0d addr=%0d count=%0d expected 1/%0d/%0d/%0d", i, din_en, din, addr, count, i + 1, i, 3 - i); end
    end
    tick();
    checks++; if (din_en !== 1'b0) begin errors++; $display("FAIL drain_end: got en=%b expected 0", din_en); end
  endtask

  task automatic test_back_to_back();
    out_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'(10 + i); in_addr = 2'(i);
      tick();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count%0d: got %0d expected 1", i, count); end
      if (i > 0) begin
        checks++; if (din_en !== 1'b1 || din !== 32'(9 + i) || addr !== 2'(i - 1)) begin
          errors++; $display("FAIL b2b_out%0d: got en=%b din=%0d addr=%0d expected 1/%0d/%0d", i, din_en, din, addr, 9 + i, i - 1); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (din_en !== 1'b1 || din !== 32'd19 || count !== 3'd0) begin
      errors++; $display("FAIL b2b_last: got en=%b din=%0d count=%0d expected 1/19/0", din_en, din, count); end
  endtask

  task automatic test_hold_toggle();
    logic [31:0] exp_d;
    logic        exp_en;
    logic [2:0]  exp_c;
    out_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'(21 + i); in_addr = 2'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL tog_fill: got %0d expected 3", count); end
    exp_d = 32'd21; exp_c = 3'd3;
    for (int i = 0; i < 5; i++) begin
      out_hold = (i == 0 || i == 2) ? 1'b1 : 1'b0;
      exp_en = ~out_hold;
      tick();
      checks++; if (din_en !== exp_en) begin errors++; $display("FAIL tog_en%0d: got %b expected %b", i, din_en, exp_en); end
      if (exp_en) begin
        exp_c = exp_c - 3'd1;
        checks++; if (din !== exp_d || count !== exp_c) begin
          errors++; $display("FAIL tog_word%0d: got din=%0d count=%0d expected %0d/%0d", i, din, count, exp_d, exp_c); end
        exp_d = exp_d + 32'd1;
      end
    end
    out_hold = 1'b0;
    tick();
    checks++; if (din_en !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL tog_end: got en=%b count=%0d expected 0/0", din_en, count); end
  endtask

  task automatic test_reset_mid();
    out_hold = 1'b1; in_valid = 1'b1; in_data = 32'd77; in_addr = 2'd1;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_hold = 1'b0;
    checks++; if (count !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL midreset: got count=%0d ready=%b expected 0/1", count, in_ready); end
    tick();
    checks++; if (din_en !== 1'b0) begin errors++; $display("FAIL midreset_discard: got en=%b expected 0", din_en); end
  endtask

`ifdef ROUTER_INGRESS_DROPCNT_EN
  task automatic test_drop_count();
    out_hold = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin in_data = 32'(i); tick(); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL drop_zero: got %0d expected 0", drop_count); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (drop_count !== 16'd5) begin errors++; $display("FAIL drop_five: got %0d expected 5", drop_count); end
    force dut.r_drop_count = 16'hFFFF;
    tick();
    release dut.r_drop_count;
    tick();
    checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL drop_sat: got %h expected ffff", drop_count); end
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_hold = 1'b0;
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL drop_reset: got %0d expected 0", drop_count); end
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_addr = 2'd0; out_hold = 1'b0;
    test_reset();
    test_single();
    test_fill_hold();
    test_back_to_back();
    test_hold_toggle();
    test_reset_mid();
`ifdef ROUTER_INGRESS_DROPCNT_EN
    test_drop_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_ingress_queue.md
# router_ingress_queue

Buffered ingress stage that sits directly upstream of the four-port simple router. It accepts addressed data words over a valid/ready handshake and queues them in a small FIFO. It presents one word per cycle on the router's `din`/`din_en`/`addr` inputs as registered outputs. A hold input lets the fabric pause issue without losing queued words.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: word width; must match the router's `DATA_WIDTH`.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  DATA_WIDTH  word to enqueue.
- `in_addr`  in  2  destination port (0–3) for `in_data`.
- `in_valid`  in  1  producer offers `in_data`/`in_addr` this cycle.
- `in_ready`  out  1  queue can accept this cycle.
- `out_hold`  in  1  when 1, no word is issued this cycle.
- `din`  out  DATA_WIDTH  registered word to the router.
- `din_en`  out  1  registered; 1 means `din`/`addr` carry a valid word this cycle.
- `addr`  out  2  registered destination for `din`.
- `count`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `drop_count`  out  16  present only with `ROUTER_INGRESS_DROPCNT_EN`; see Configuration.

## Operation

- Storage is a circular buffer of `DEPTH` entries of {`in_addr`, `in_data`}, with a write pointer and a read pointer of log2(`DEPTH`) bits each. Both pointers wrap modulo `DEPTH`. Occupancy is tracked in `count`.
- `in_ready` is 1 exactly when `count < DEPTH`. It is combinational from `count` only and does not depend on `out_hold` or on a same-cycle pop.
- Push: when `in_valid && in_ready`, the entry is written at the write pointer, and the write pointer advances.
- Pop: when `!out_hold && count != 0`, on the next edge:
  - the head entry loads into `din`/`addr`;
  - `din_en` becomes 1;
  - the read pointer advances.
- Otherwise `din_en` becomes 0, and `din`/`addr` keep their previous values.
- A push and a pop in the same cycle are both performed and `count` is unchanged. This applies at any non-full occupancy; when full, no push is possible.
- On empty with `out_hold=0`, no pop occurs and `din_en` becomes 0.
- Order is strict FIFO. No reordering by destination, and no bypass path.
- Reset, at any time including mid-traffic:
  - pointers, `count`, `din`, `addr` and `din_en` all go to 0;
  - queued entries are discarded;
  - `in_ready` is 1 in the cycle after reset deasserts.
- FIFO storage contents are not reset.
- While `reset` is high, pushes and pops are ignored.

## Timing

- Acceptance-to-issue latency: a word accepted at edge N into an empty queue, with `out_hold=0`, is visible with `din_en=1` after edge N+1.
- Throughput: one word per cycle in steady state with `out_hold=0`.
- `out_hold` takes effect at the next edge. If `out_hold=1` in cycle C, then `din_en=0` after the edge ending C.
- `count` reflects the edge-registered occupancy.
- Reset values: `din=0`, `din_en=0`, `addr=0`, `count=0`, `in_ready=1`, `drop_count=0`.

## Configuration

- `ROUTER_INGRESS_DROPCNT_EN` defined:
  - the `drop_count` port and a 16-bit register exist;
  - the register increments on each cycle with `in_valid && !in_ready && !reset`;
  - it saturates at 16'hFFFF and clears only on `reset`.
- Macro undefined: the port and register are absent. All other behaviour is identical.

## Test plan

- Reset with `in_valid=1` held: `din_en=0`, `count=0`, `in_ready=1` after deassert; no word is accepted while `reset` is high.
- Single push {`in_addr`=2, `in_data`=32'hA5A5_0001} at edge N into an empty queue, `out_hold=0`: after N+1, `din_en=1`, `addr=2`, `din`=32'hA5A5_0001; after N+2, `din_en=0`.
- `out_hold=1`, push 4 words (addr 0,1,2,3; data 1,2,3,4): `count=4`, `in_ready=0`, a 5th offer is not accepted. Then `out_hold=0`: words issue on 4 consecutive cycles in order 1,2,3,4 with addresses 0,1,2,3.
- Continuous push of data 10..19 with `out_hold=0`: `count` stays at 1, and `din` emits 10..19 on consecutive cycles.
- Queue holding 3 words, `out_hold` toggled 1,0,1,0: `din_en` follows 0,1,0,1; no word is lost or duplicated.
- With `ROUTER_INGRESS_DROPCNT_EN`, full queue and `in_valid=1` for 5 cycles: `drop_count=5`; a forced value of 16'hFFFF stays at 16'hFFFF; `reset` returns it to 0.
